// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Optional even-parity support is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_deser_if.sv
// Receive-side bus between the serial line, the deserializer and the RX buffer writer.
// The master modport drives the line and observes the results; the slave modport is the deserializer.
interface uart_rx_deser_if #(
    parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS_DEF
);
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx,
        input  rx_data, rx_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  rx,
        output rx_data, rx_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous UART input plus a previous-value flop for edge detect.
// All flops reset to 1 so an idle-high line produces no spurious edge after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: frames 8N1 characters LSB first and strobes each good byte.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input logic            clk,
    input logic            rstn,
    uart_rx_deser_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall;

    rx_state_e             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_busy;
`ifdef UART_RX_PARITY_EN
    logic                  r_parity_err;
    logic                  r_par_bad;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (bus.rx),
        .o_sync  (w_rx_s),
        .o_fall  (w_fall)
    );

    // Frame FSM: all samples taken mid-bit; IDLE is re-entered at the stop-bit midpoint.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BIDX_LAST) begin
                            r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= PARITY;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + BIDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bad <= ^{r_shift, w_rx_s};
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
